// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the cache fill controller and its helpers.
// The offset-width helper keeps the block-offset arithmetic in one place.
package cache_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam int DEF_ADDR_W      = 15;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_BLOCK_WORDS = 4;
   localparam int DEF_CNT_W       = 16;

   // Word-offset width within a block; never narrower than one bit.
   function automatic int off_w(input int block_words);
      return (block_words <= 2) ? 1 : $clog2(block_words);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the hit and miss statistics.
module sat_counter
   import cache_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_fill_controller.sv
// Serves CPU reads from the cache on a hit and refills a whole block from RAM
// on a miss, forwarding the critical word and flagging fill completion.
module cache_fill_controller
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] address,
   input  logic              hit,
   input  logic [DATA_W-1:0] cache_rdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cache_we,
   output logic [ADDR_W-1:0] cache_waddr,
   output logic [DATA_W-1:0] cache_wdata,
   output logic              fill_done,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int               OFF_W     = off_w(BLOCK_WORDS);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] miss_addr;
   logic [OFF_W-1:0]  beat;
   logic [ADDR_W-1:0] fill_addr;
   logic              accept_hit;
   logic              accept_miss;
   logic              beat_valid;

   assign accept_hit  = (state == IDLE) && cpu_req && hit;
   assign accept_miss = (state == IDLE) && cpu_req && !hit;
   assign beat_valid  = (state == FILL) && mem_rvalid;

   // The beat index replaces the offset, so a refill never leaves its block.
   assign fill_addr   = {miss_addr[ADDR_W-1:OFF_W], beat};

   assign cpu_ready   = (state == RESPOND);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               state_next = hit ? RESPOND : FILL;
            end
         end
         FILL: begin
            if (mem_rvalid && (beat == LAST_BEAT)) begin
               state_next = RESPOND;
            end
         end
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req     = 1'b0;
      mem_addr    = '0;
      cache_we    = 1'b0;
      cache_waddr = '0;
      cache_wdata = '0;
      fill_done   = 1'b0;
      if (state == FILL) begin
         mem_req  = 1'b1;
         mem_addr = fill_addr;
         if (mem_rvalid) begin
            cache_we    = 1'b1;
            cache_waddr = fill_addr;
            cache_wdata = mem_rdata;
            fill_done   = (beat == LAST_BEAT);
         end
      end
   end

   // The requested word is captured as it streams past, not read back later.
   always_ff @(posedge clk) begin
      if (rst) begin
         miss_addr <= '0;
         beat      <= '0;
         cpu_rdata <= '0;
      end else begin
         if (accept_miss) begin
            miss_addr <= address;
            beat      <= '0;
         end
         if (accept_hit) begin
            cpu_rdata <= cache_rdata;
         end
         if (beat_valid) begin
            beat <= beat + OFF_W'(1);
            if (beat == miss_addr[OFF_W-1:0]) begin
               cpu_rdata <= mem_rdata;
            end
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hit_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept_hit),
      .count (hit_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept_miss),
      .count (miss_count)
   );

endmodule

// File: tb/tb_cache_fill_controller.sv
// Self-checking bench: directed vector table, hand-written reset and
// back-to-back sequences, then randomized transactions against a model.
module tb_cache_fill_controller;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int BW     = 4;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic             isHit;
      logic [ADDR_W-1:0] addr;
      logic [31:0]      data;
      logic [3:0][3:0]  stall;
      logic [31:0]      expRdata;
      logic [7:0]       expLat;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req;
   logic [ADDR_W-1:0] address;
   logic              hit;
   logic [DATA_W-1:0] cache_rdata;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              cpu_ready, cache_we, fill_done, mem_req;
   logic [DATA_W-1:0] cpu_rdata, cache_wdata;
   logic [ADDR_W-1:0] cache_waddr, mem_addr;
   logic [CNT_W-1:0]  hit_count, miss_count;

   logic              s_cpu_ready, s_cache_we, s_fill_done, s_mem_req;
   logic [DATA_W-1:0] s_cpu_rdata, s_cache_wdata;
   logic [ADDR_W-1:0] s_cache_waddr, s_mem_addr;
   logic [3:0]        s_hit_count, s_miss_count;

   int checks = 0;
   int errors = 0;
   int modelHits = 0;
   int modelMisses = 0;

   vec_t vecs[6];

   cache_fill_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .address(address), .hit(hit),
      .cache_rdata(cache_rdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
      .fill_done(fill_done), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   cache_fill_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .address(address), .hit(hit),
      .cache_rdata(cache_rdata), .cpu_ready(s_cpu_ready), .cpu_rdata(s_cpu_rdata),
      .cache_we(s_cache_we), .cache_waddr(s_cache_waddr), .cache_wdata(s_cache_wdata),
      .fill_done(s_fill_done), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] satv(input int n, input int w);
      int m;
      m = (1 << w) - 1;
      return 32'((n > m) ? m : n);
   endfunction

   task automatic checkCounters();
      checkOutput("hit_count", 32'(hit_count), satv(modelHits, CNT_W));
      checkOutput("miss_count", 32'(miss_count), satv(modelMisses, CNT_W));
      checkOutput("sat4 hit_count", 32'(s_hit_count), satv(modelHits, 4));
      checkOutput("sat4 miss_count", 32'(s_miss_count), satv(modelMisses, 4));
   endtask

   function automatic vec_t mkVec(input logic isHit, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                  input logic [15:0] st, input logic [31:0] er, input int lat);
      vec_t v;
      v.isHit    = isHit;
      v.addr     = a;
      v.data     = d;
      v.stall    = st;
      v.expRdata = er;
      v.expLat   = 8'(lat);
      return v;
   endfunction

   // Expected values come from the block/offset rules, not the DUT's state.
   function automatic vec_t randVec();
      logic              isHit;
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
      logic [15:0]       st;
      int                total;
      isHit = 1'($urandom);
      a     = ADDR_W'($urandom);
      d     = $urandom;
      st    = '0;
      total = 0;
      for (int i = 0; i < BW; i++) begin
         int s;
         s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         st[i*4 +: 4] = 4'(s);
         total += s;
      end
      if (isHit) return mkVec(1'b1, a, d, 16'h0, d, 1);
      return mkVec(1'b0, a, d, st, d + 32'(int'(a) % BW), BW + 1 + total);
   endfunction

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; cpu_req = 1'b0; hit = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      #1;
      modelHits = 0;
      modelMisses = 0;
      checkOutput("reset cpu_ready", 32'(cpu_ready), 32'd0);
      checkOutput("reset cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("reset mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset cache_we", 32'(cache_we), 32'd0);
      checkOutput("reset cache_waddr", 32'(cache_waddr), 32'd0);
      checkOutput("reset cache_wdata", cache_wdata, 32'd0);
      checkOutput("reset fill_done", 32'(fill_done), 32'd0);
      checkCounters();
   endtask

   task automatic applyStimulus(input vec_t v, input logic holdReq);
      logic [ADDR_W-1:0] base;
      int  b;
      int  left;
      int  lat;
      logic seen;
      @(negedge clk);
      rst = 1'b0; cpu_req = 1'b1; address = v.addr; hit = v.isHit;
      cache_rdata = v.isHit ? v.data : $urandom;
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      #1;
      checkOutput("accept cpu_ready", 32'(cpu_ready), 32'd0);
      checkOutput("accept mem_req", 32'(mem_req), 32'd0);
      checkOutput("accept cache_we", 32'(cache_we), 32'd0);
      if (v.isHit) modelHits++; else modelMisses++;
      lat = 0;
      if (!v.isHit) begin
         base = ADDR_W'((int'(v.addr) / BW) * BW);
         b = 0;
         left = int'(v.stall[0]);
         while (b < BW) begin
            @(negedge clk);
            lat++;
            cpu_req = holdReq; address = ADDR_W'($urandom); hit = 1'($urandom); cache_rdata = $urandom;
            if (left > 0) begin
               mem_rvalid = 1'b0; mem_rdata = $urandom; left--;
            end else begin
               mem_rvalid = 1'b1; mem_rdata = v.data + 32'(b);
            end
            #1;
            checkOutput("fill mem_req", 32'(mem_req), 32'd1);
            checkOutput("fill mem_addr", 32'(mem_addr), 32'(base) + 32'(b));
            checkOutput("fill cache_we", 32'(cache_we), 32'(mem_rvalid));
            checkOutput("fill fill_done", 32'(fill_done), 32'(mem_rvalid && (b == BW - 1)));
            checkOutput("fill cpu_ready", 32'(cpu_ready), 32'd0);
            if (mem_rvalid) begin
               checkOutput("fill cache_waddr", 32'(cache_waddr), 32'(base) + 32'(b));
               checkOutput("fill cache_wdata", cache_wdata, v.data + 32'(b));
               b++;
               if (b < BW) left = int'(v.stall[b]);
            end
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
         @(negedge clk);
         lat++;
         cpu_req = holdReq; address = ADDR_W'($urandom); hit = 1'($urandom); cache_rdata = $urandom;
         mem_rvalid = 1'($urandom); mem_rdata = $urandom;
         #1;
         if (cpu_ready) seen = 1'b1;
      end
      checkOutput("response seen", 32'(seen), 32'd1);
      if (seen) begin
         checkOutput("latency", 32'(lat), 32'(v.expLat));
         checkOutput("cpu_rdata", cpu_rdata, v.expRdata);
         checkOutput("respond mem_req", 32'(mem_req), 32'd0);
         checkOutput("respond cache_we", 32'(cache_we), 32'd0);
         checkCounters();
      end
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; hit = 1'b0; address = '0;
      cache_rdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;

      vecs[0] = mkVec(1'b1, 15'h0012, 32'hDEADBEEF, 16'h0000, 32'hDEADBEEF, 1);
      vecs[1] = mkVec(1'b0, 15'h0106, 32'h000000A0, 16'h0000, 32'h000000A2, 5);
      vecs[2] = mkVec(1'b0, 15'h0106, 32'h000000A0, 16'h0020, 32'h000000A2, 7);
      vecs[3] = mkVec(1'b0, 15'h0200, 32'h11110000, 16'h0000, 32'h11110000, 5);
      vecs[4] = mkVec(1'b0, 15'h7FFF, 32'hFFFFFFF0, 16'h3001, 32'hFFFFFFF3, 9);
      vecs[5] = mkVec(1'b1, 15'h7FFF, 32'h5A5A1234, 16'h0000, 32'h5A5A1234, 1);

      $display("[TB] directed vectors");
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0);

      $display("[TB] reset during fill");
      doReset();
      @(negedge clk);
      rst = 1'b0; cpu_req = 1'b1; hit = 1'b0; address = 15'h0106; mem_rvalid = 1'b0;
      @(negedge clk);
      cpu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0;
      @(negedge clk);
      mem_rdata = 32'hA1;
      #1;
      checkOutput("midfill mem_addr", 32'(mem_addr), 32'h0105);
      @(negedge clk);
      rst = 1'b1; mem_rvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA2;
      #1;
      modelHits = 0;
      modelMisses = 0;
      checkOutput("post-reset mem_req", 32'(mem_req), 32'd0);
      checkOutput("post-reset cache_we", 32'(cache_we), 32'd0);
      checkOutput("post-reset fill_done", 32'(fill_done), 32'd0);
      checkOutput("post-reset cpu_ready", 32'(cpu_ready), 32'd0);
      checkCounters();
      @(negedge clk);
      mem_rdata = 32'hA3;
      #1;
      checkOutput("post-reset idle fill_done", 32'(fill_done), 32'd0);
      checkOutput("post-reset idle cpu_ready", 32'(cpu_ready), 32'd0);
      applyStimulus(mkVec(1'b1, 15'h0040, 32'h12345678, 16'h0, 32'h12345678, 1), 1'b0);

      $display("[TB] reset during respond");
      @(negedge clk);
      cpu_req = 1'b1; hit = 1'b1; address = 15'h0033; cache_rdata = 32'hCAFEF00D; mem_rvalid = 1'b0;
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      checkOutput("respond before reset", 32'(cpu_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      modelHits = 0;
      modelMisses = 0;
      checkOutput("lost response cpu_ready", 32'(cpu_ready), 32'd0);
      checkOutput("lost response cpu_rdata", cpu_rdata, 32'd0);
      checkCounters();

      $display("[TB] back-to-back with request held");
      doReset();
      applyStimulus(mkVec(1'b1, 15'h0001, 32'h01010101, 16'h0, 32'h01010101, 1), 1'b1);
      applyStimulus(mkVec(1'b0, 15'h0105, 32'h00000B00, 16'h0, 32'h00000B01, 5), 1'b1);
      applyStimulus(mkVec(1'b1, 15'h0002, 32'h02020202, 16'h0, 32'h02020202, 1), 1'b0);
      checkOutput("b2b hit_count", 32'(hit_count), 32'd2);
      checkOutput("b2b miss_count", 32'(miss_count), 32'd1);

      $display("[TB] saturation");
      doReset();
      for (int i = 0; i < 20; i++) begin
         logic [31:0] d;
         d = $urandom;
         applyStimulus(mkVec(1'b1, ADDR_W'($urandom), d, 16'h0, d, 1), 1'b1);
      end
      checkOutput("sat4 final hit_count", 32'(s_hit_count), 32'd15);
      checkOutput("wide final hit_count", 32'(hit_count), 32'd20);

      $display("[TB] randomized transactions");
      doReset();
      for (int i = 0; i < 40; i++) applyStimulus(randVec(), 1'($urandom));

      @(negedge clk);
      cpu_req = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
